// File: rtl/capsense_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capsense_scan_pkg
// Purpose  : Board capsense constants, scanner state encoding and shared
//            helpers for the multi-channel capacitive-touch scanner.
// Revision : 1.0 - initial release
// ============================================================================
package capsense_scan_pkg;

    // Board package constants: capsense path present and its pad count.
    localparam bit c_CAPSENSE  = 1'b1;
    localparam int c_NUM_SENSE = 4;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        CHARGE    = 2'd2,
        EVAL      = 2'd3
    } capsense_state_e;

    // Unsigned subtraction clamped at zero (release threshold never underflows).
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (b > a) ? 32'd0 : (a - b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/capsense_chan_filter.sv
`default_nettype none
// ============================================================================
// Module   : capsense_chan_filter
// Purpose  : Per-channel touch classifier: hysteresis compare of one scan
//            count followed by a scan-count debounce of the touched bit.
// Revision : 1.0 - initial release
// ============================================================================
module capsense_chan_filter
    import capsense_scan_pkg::*;
#(
    parameter int CountWidth    = 12,
    parameter int DebounceScans = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  eval,
    input  logic [CountWidth-1:0] count,
    input  logic                  timeout,
    input  logic [CountWidth-1:0] thresh_on,
    input  logic [CountWidth-1:0] hysteresis,
    output logic                  touched
);

    // Debounce counter only ever holds 0..DebounceScans-1.
    localparam int               c_DBW     = (DebounceScans > 1) ? $clog2(DebounceScans) : 1;
    localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DebounceScans - 1);

    logic [CountWidth-1:0] w_thresh_off;
    logic                  w_sample;
    logic [c_DBW-1:0]      r_db_cnt;
    logic                  r_touched;

    // Classify this scan's count: on, off, or hold the current state in the band.
    always_comb begin
        w_thresh_off = CountWidth'(sat_sub(32'(thresh_on), 32'(hysteresis)));
        if (timeout || (count >= thresh_on)) begin
            w_sample = 1'b1;
        end else if (count < w_thresh_off) begin
            w_sample = 1'b0;
        end else begin
            w_sample = r_touched;
        end
    end

    // Toggle touched only after DebounceScans consecutive disagreeing scans.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_touched <= 1'b0;
            r_db_cnt  <= '0;
        end else if (eval) begin
            if (w_sample != r_touched) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_touched <= w_sample;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign touched = r_touched;

endmodule
`default_nettype wire

// File: rtl/capsense_scan.sv
`default_nettype none
// ============================================================================
// Module   : capsense_scan
// Purpose  : Multi-channel capacitive-touch scanner. Discharges all pads,
//            releases them, times each pad's rise, then publishes counts,
//            timeouts and debounced touch state once per scan.
// Revision : 1.0 - initial release
// ============================================================================
module capsense_scan
    import capsense_scan_pkg::*;
#(
    parameter int NumSense        = c_CAPSENSE ? c_NUM_SENSE : 1,
    parameter int CountWidth      = 12,
    parameter int DischargeCycles = 64,
    parameter int DebounceScans   = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [CountWidth-1:0]          thresh_on,
    input  logic [CountWidth-1:0]          hysteresis,
    input  logic [NumSense-1:0]            sense_in,
    output logic [NumSense-1:0]            sense_oe,
    output logic [NumSense*CountWidth-1:0] raw_count,
    output logic [NumSense-1:0]            timeout,
    output logic [NumSense-1:0]            touched,
    output logic                           scan_done
);

    localparam int                    c_DCW      = (DischargeCycles > 1) ? $clog2(DischargeCycles) : 1;
    localparam logic [c_DCW-1:0]      c_DIS_LAST = c_DCW'(DischargeCycles - 1);
    localparam logic [CountWidth-1:0] c_CNT_MAX  = '1;

    capsense_state_e                r_state;
    logic [NumSense-1:0]            r_sync1;
    logic [NumSense-1:0]            r_sync2;
    logic [c_DCW-1:0]               r_dis_cnt;
    logic [CountWidth-1:0]          r_cnt;
    logic [NumSense-1:0]            r_done;
    logic [NumSense*CountWidth-1:0] r_shadow;
    logic [NumSense-1:0]            r_shadow_to;
    logic [NumSense-1:0]            r_oe;
    logic [NumSense*CountWidth-1:0] r_raw;
    logic [NumSense-1:0]            r_to;
    logic                           r_scan_done;

    logic                           w_max;
    logic [NumSense-1:0]            w_capture;
    logic [NumSense-1:0]            w_force;
    logic [NumSense-1:0]            w_done_next;
    logic                           w_eval;
    logic [NumSense-1:0]            w_touched;

    // Two-flop synchroniser on the asynchronous pad levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sense_in;
            r_sync2 <= r_sync1;
        end
    end

    // Capture decisions: a rising pad wins over the max-count forced timeout.
    always_comb begin
        w_max       = (r_cnt == c_CNT_MAX);
        w_capture   = ~r_done & r_sync2;
        w_force     = w_max ? (~r_done & ~r_sync2) : '0;
        w_done_next = r_done | w_capture | w_force;
        w_eval      = (r_state == EVAL);
    end

    // Scan sequencer with registered pad enables and published results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_dis_cnt   <= '0;
            r_cnt       <= '0;
            r_done      <= '0;
            r_shadow    <= '0;
            r_shadow_to <= '0;
            r_oe        <= '1;
            r_raw       <= '0;
            r_to        <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_oe      <= '1;
                    r_dis_cnt <= '0;
                    if (enable) begin
                        r_state <= DISCHARGE;
                    end
                end
                DISCHARGE: begin
                    r_oe        <= '1;
                    r_done      <= '0;
                    r_cnt       <= '0;
                    r_shadow_to <= '0;
                    if (r_dis_cnt == c_DIS_LAST) begin
                        r_state <= CHARGE;
                        r_oe    <= '0;
                    end else begin
                        r_dis_cnt <= r_dis_cnt + 1'b1;
                    end
                end
                CHARGE: begin
                    for (int i = 0; i < NumSense; i++) begin
                        if (w_capture[i] || w_force[i]) begin
                            r_shadow[i*CountWidth +: CountWidth] <= r_cnt;
                        end
                    end
                    r_shadow_to <= r_shadow_to | w_force;
                    r_done      <= w_done_next;
                    // Counter holds at max rather than wrapping.
                    if (!w_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (&w_done_next) begin
                        r_state <= EVAL;
                        r_oe    <= '1;
                    end
                end
                EVAL: begin
                    r_raw       <= r_shadow;
                    r_to        <= r_shadow_to;
                    r_scan_done <= 1'b1;
                    r_dis_cnt   <= '0;
                    r_state     <= enable ? DISCHARGE : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_oe    <= '1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NumSense; g++) begin : g_chan
        capsense_chan_filter #(
            .CountWidth    (CountWidth),
            .DebounceScans (DebounceScans)
        ) u_filter (
            .clk        (clk),
            .reset_n    (reset_n),
            .eval       (w_eval),
            .count      (r_shadow[g*CountWidth +: CountWidth]),
            .timeout    (r_shadow_to[g]),
            .thresh_on  (thresh_on),
            .hysteresis (hysteresis),
            .touched    (w_touched[g])
        );
    end

    assign sense_oe  = r_oe;
    assign raw_count = r_raw;
    assign timeout   = r_to;
    assign touched   = w_touched;
    assign scan_done = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_capsense_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_capsense_scan
// Purpose  : Self-checking bench for capsense_scan (4 channels, 8-bit counts)
//            with an RC pad model and a scoreboard of expected scan results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capsense_scan;

    localparam int N  = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic [N*CW-1:0] cnt;
        logic [N-1:0]    to;
        logic [N-1:0]    tch;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [CW-1:0]   thresh_on;
    logic [CW-1:0]   hysteresis;
    logic [N-1:0]    sense_in;
    logic [N-1:0]    sense_oe;
    logic [N*CW-1:0] raw_count;
    logic [N-1:0]    timeout;
    logic [N-1:0]    touched;
    logic            scan_done;

    int   delay [N];
    logic [N-1:0] stuck;
    int   pad_cyc = 0;
    int   last_charge_len = 0;
    int   pulses = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    bit   m_touched [N];
    int   m_db [N];

    capsense_scan #(
        .NumSense        (N),
        .CountWidth      (CW),
        .DischargeCycles (8),
        .DebounceScans   (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .thresh_on  (thresh_on),
        .hysteresis (hysteresis),
        .sense_in   (sense_in),
        .sense_oe   (sense_oe),
        .raw_count  (raw_count),
        .timeout    (timeout),
        .touched    (touched),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    // Pad model: held low while driven, rises delay[i] cycles into the charge phase.
    always @(negedge clk) begin
        if (sense_oe === '1) begin
            if (pad_cyc != 0) last_charge_len = pad_cyc;
            pad_cyc  = 0;
            sense_in = '0;
        end else begin
            for (int i = 0; i < N; i++) sense_in[i] = !stuck[i] && (pad_cyc >= delay[i]);
            pad_cyc++;
        end
    end

    // Count scan_done pulses.
    always @(negedge clk) begin
        if (scan_done === 1'b1) pulses++;
    end

    function automatic bit model_sample(input int c, input bit t, input bit cur);
        int on;
        int off;
        on  = int'(thresh_on);
        off = (int'(hysteresis) > on) ? 0 : on - int'(hysteresis);
        if (t || c >= on) return 1'b1;
        if (c < off) return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_touched[i] = 1'b0;
            m_db[i]      = 0;
        end
    endtask

    // Program the pads for the next scan and push its expected result.
    task automatic prepare(input int d0, input int d1, input int d2, input int d3, input logic [N-1:0] stk);
        exp_t e;
        int   d [N];
        d = '{d0, d1, d2, d3};
        stuck = stk;
        for (int i = 0; i < N; i++) begin
            int c;
            bit t;
            bit s;
            delay[i] = d[i];
            t = stk[i] || (d[i] + 2 > 255);
            c = t ? 255 : d[i] + 2;
            e.cnt[i*CW +: CW] = CW'(c);
            e.to[i] = t;
            s = model_sample(c, t, m_touched[i]);
            if (s != m_touched[i]) begin
                m_db[i]++;
                if (m_db[i] == 3) begin
                    m_touched[i] = s;
                    m_db[i]      = 0;
                end
            end else begin
                m_db[i] = 0;
            end
            e.tch[i] = m_touched[i];
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next scan_done and compare against the scoreboard.
    task automatic collect(input string tag);
        exp_t e;
        int   n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scan_done !== 1'b1 && n < 3000);
        e = sb.pop_front();
        vectors++;
        if (scan_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s scan_done: no pulse after %0d cycles, required a pulse", tag, n);
            return;
        end
        vectors++;
        if (raw_count !== e.cnt) begin
            miscompares++;
            $display("FAIL %s raw_count: got %h required %h", tag, raw_count, e.cnt);
        end
        vectors++;
        if (timeout !== e.to) begin
            miscompares++;
            $display("FAIL %s timeout: got %b required %b", tag, timeout, e.to);
        end
        if (touched !== e.tch) begin
            miscompares++;
            $display("FAIL %s touched: got %b required %b", tag, touched, e.tch);
        end
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3,
                        input logic [N-1:0] stk, input string tag);
        prepare(d0, d1, d2, d3, stk);
        collect(tag);
    endtask

    task automatic wait_charge(input string tag);
        int n = 0;
        while (sense_oe !== '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sense_oe !== '0) begin
            miscompares++;
            $display("FAIL %s charge entry: sense_oe %b after %0d cycles, required 0000", tag, sense_oe, n);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int p0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (sense_oe !== 4'hF) begin miscompares++; $display("FAIL reset sense_oe: got %b required 1111", sense_oe); end
        vectors++;
        if (raw_count !== '0) begin miscompares++; $display("FAIL reset raw_count: got %h required 0", raw_count); end
        vectors++;
        if (timeout !== '0) begin miscompares++; $display("FAIL reset timeout: got %b required 0", timeout); end
        vectors++;
        if (touched !== '0) begin miscompares++; $display("FAIL reset touched: got %b required 0", touched); end
        vectors++;
        if (scan_done !== 1'b0) begin miscompares++; $display("FAIL reset scan_done: got %b required 0", scan_done); end
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        p0 = pulses;
        repeat (1000) @(negedge clk);
        #1;
        vectors++;
        if (pulses != p0) begin miscompares++; $display("FAIL idle scan_done pulses: got %0d required 0", pulses - p0); end
        vectors++;
        if (sense_oe !== 4'hF) begin miscompares++; $display("FAIL idle sense_oe: got %b required 1111", sense_oe); end
    endtask

    task automatic test_timing();
        int p0;
        thresh_on  = 8'd200;
        hysteresis = 8'd0;
        p0 = pulses;
        enable = 1'b1;
        scan(10, 20, 30, 40, 4'b0000, "timing_a");
        vectors++;
        if (last_charge_len != 43) begin miscompares++; $display("FAIL timing_a charge length: got %0d required 43", last_charge_len); end
        @(negedge clk);
        #1;
        vectors++;
        if (pulses - p0 != 1) begin miscompares++; $display("FAIL timing_a scan_done pulses: got %0d required 1", pulses - p0); end
        vectors++;
        if (scan_done !== 1'b0) begin miscompares++; $display("FAIL timing_a scan_done width: got %b required 0", scan_done); end
        scan(0, 5, 17, 3, 4'b0000, "timing_b");
        vectors++;
        if (last_charge_len != 20) begin miscompares++; $display("FAIL timing_b charge length: got %0d required 20", last_charge_len); end
    endtask

    task automatic test_timeout();
        scan(5, 15, 0, 25, 4'b0100, "timeout_ch2");
        vectors++;
        if (last_charge_len != 256) begin miscompares++; $display("FAIL timeout_ch2 charge length: got %0d required 256", last_charge_len); end
        scan(0, 1, 1, 200, 4'b0001, "timeout_ch0");
    endtask

    task automatic test_hysteresis();
        apply_reset();
        thresh_on  = 8'd100;
        hysteresis = 8'd20;
        enable     = 1'b1;
        scan(103, 148, 18, 0, 4'b1000, "hyst_on1");
        scan(103, 148, 18, 0, 4'b1000, "hyst_on2");
        vectors++;
        if (touched[0] !== 1'b0) begin miscompares++; $display("FAIL hyst_on2 touched0: got %b required 0", touched[0]); end
        scan(103, 148, 18, 0, 4'b1000, "hyst_on3");
        vectors++;
        if (touched[0] !== 1'b1) begin miscompares++; $display("FAIL hyst_on3 touched0: got %b required 1", touched[0]); end
        scan(88, 148, 18, 0, 4'b1000, "hyst_hold");
        vectors++;
        if (touched[0] !== 1'b1) begin miscompares++; $display("FAIL hyst_hold touched0: got %b required 1", touched[0]); end
        for (int k = 0; k < 3; k++) scan(68, 148, 18, 0, 4'b1000, "hyst_off");
        vectors++;
        if (touched[0] !== 1'b0) begin miscompares++; $display("FAIL hyst_off touched0: got %b required 0", touched[0]); end
        for (int k = 0; k < 5; k++) scan((k % 2 == 0) ? 68 : 103, 148, 18, 0, 4'b1000, "hyst_alt");
        vectors++;
        if (touched[0] !== 1'b0) begin miscompares++; $display("FAIL hyst_alt touched0: got %b required 0", touched[0]); end
    endtask

    task automatic test_saturation();
        apply_reset();
        thresh_on  = 8'd10;
        hysteresis = 8'd50;
        enable     = 1'b1;
        for (int k = 0; k < 3; k++) scan(10, 0, 50, 5, 4'b0000, "sat_set");
        vectors++;
        if (touched[0] !== 1'b1) begin miscompares++; $display("FAIL sat_set touched0: got %b required 1", touched[0]); end
        for (int k = 0; k < 4; k++) scan(0, 0, 50, 5, 4'b0000, "sat_hold");
        vectors++;
        if (touched[1:0] !== 2'b01) begin miscompares++; $display("FAIL sat_hold touched1:0: got %b required 01", touched[1:0]); end
    endtask

    task automatic test_reset_midscan();
        delay = '{200, 200, 200, 200};
        stuck = '0;
        wait_charge("reset_mid");
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (sense_oe !== 4'hF) begin miscompares++; $display("FAIL reset_mid sense_oe: got %b required 1111", sense_oe); end
        vectors++;
        if (touched !== '0) begin miscompares++; $display("FAIL reset_mid touched: got %b required 0", touched); end
        vectors++;
        if (raw_count !== '0 || timeout !== '0 || scan_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid results: got raw %h to %b done %b required all 0", raw_count, timeout, scan_done);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int p0;
        thresh_on  = 8'd100;
        hysteresis = 8'd20;
        prepare(33, 44, 55, 66, 4'b0000);
        enable = 1'b1;
        wait_charge("enable_drop");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        collect("enable_drop");
        @(negedge clk);
        #1;
        p0 = pulses;
        repeat (300) @(negedge clk);
        #1;
        vectors++;
        if (pulses != p0) begin miscompares++; $display("FAIL enable_drop idle pulses: got %0d required 0", pulses - p0); end
        vectors++;
        if (sense_oe !== 4'hF) begin miscompares++; $display("FAIL enable_drop idle sense_oe: got %b required 1111", sense_oe); end
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        thresh_on  = '0;
        hysteresis = '0;
        sense_in   = '0;
        stuck      = '0;
        delay      = '{1000, 1000, 1000, 1000};
        model_reset();
        test_reset();
        test_timing();
        test_timeout();
        test_hysteresis();
        test_saturation();
        test_reset_midscan();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
